// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls the open-drain clock low to inhibit the device and then issues a
// request-to-send. It shifts one command byte out on the device-generated
// clock and reports the device ACK as tx_done, or a NACK/timeout as tx_error.
// Optional build macro PS2_TX_RETRY_EN: a failed attempt is retried from the
// inhibit phase with the same byte, up to two times, before tx_error is raised.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 3240,
    parameter int REQ_CYC     = 27,
    parameter int TIMEOUT_CYC = 540000
) (
    input  logic       CLOCK_27,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit
);

    // One shared cycle counter serves the inhibit, request and timeout
    // phases, so it is sized for the largest of the three.
    localparam int MAX_AB  = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int MAX_CYC = (TIMEOUT_CYC > MAX_AB) ? TIMEOUT_CYC : MAX_AB;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

    // Saturating increment so a stuck counter can never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       bit_idx_r;
    logic [9:0]       frame_r;      // {stop, parity, d7..d0}, sent LSB first
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_cnt_r;
`endif

    logic clk_sync1_r;
    logic clk_sync2_r;
    logic clk_prev_r;
    logic dat_sync1_r;
    logic dat_sync2_r;

    logic clk_fall_s;
    logic timeout_hit_s;
    logic attempt_failed_s;

    // Two-flop synchronisers for both pins plus a delayed clock copy for
    // edge detection; reset to the released (high) bus level.
    always_ff @(posedge CLOCK_27) begin
        if (RESET) begin
            clk_sync1_r <= 1'b1;
            clk_sync2_r <= 1'b1;
            clk_prev_r  <= 1'b1;
            dat_sync1_r <= 1'b1;
            dat_sync2_r <= 1'b1;
        end else begin
            clk_sync1_r <= ps2_clk_in;
            clk_sync2_r <= clk_sync1_r;
            clk_prev_r  <= clk_sync2_r;
            dat_sync1_r <= ps2_dat_in;
            dat_sync2_r <= dat_sync1_r;
        end
    end

    assign clk_fall_s    = clk_prev_r & ~clk_sync2_r;
    assign timeout_hit_s = (cnt_r == TMO_LAST);

    // An attempt fails on timeout in any device-clocked state, or when the
    // device leaves data high at the ACK clock edge.
    always_comb begin
        attempt_failed_s = 1'b0;
        case (state_r)
            ST_SHIFT, ST_WAIT_IDLE: begin
                attempt_failed_s = timeout_hit_s;
            end
            ST_ACK: begin
                attempt_failed_s = timeout_hit_s | (clk_fall_s & dat_sync2_r);
            end
            default: begin
                attempt_failed_s = 1'b0;
            end
        endcase
    end

    // Transmit sequencer: owns state, counters and every registered output.
    always_ff @(posedge CLOCK_27) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 4'd0;
            frame_r     <= 10'd0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_r <= 2'd0;
`endif
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            rx_inhibit  <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (attempt_failed_s) begin
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt_r < 2'd2) begin
                    // Restart the whole request with the same latched frame.
                    retry_cnt_r <= retry_cnt_r + 2'd1;
                    state_r     <= ST_INHIBIT;
                    cnt_r       <= '0;
                    bit_idx_r   <= 4'd0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_dat_oe  <= 1'b0;
                end else begin
                    state_r    <= ST_FAIL;
                    cnt_r      <= '0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                end
`else
                state_r    <= ST_FAIL;
                cnt_r      <= '0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (tx_valid && tx_ready) begin
                            frame_r     <= {1'b1, odd_parity(tx_data), tx_data};
                            tx_ready    <= 1'b0;
                            rx_inhibit  <= 1'b1;
                            ps2_clk_oe  <= 1'b1;
                            cnt_r       <= '0;
                            bit_idx_r   <= 4'd0;
`ifdef PS2_TX_RETRY_EN
                            retry_cnt_r <= 2'd0;
`endif
                            state_r     <= ST_INHIBIT;
                        end else begin
                            // Rises one cycle after a done/error pulse.
                            tx_ready   <= 1'b1;
                            rx_inhibit <= 1'b0;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt_r == INH_LAST) begin
                            cnt_r      <= '0;
                            ps2_dat_oe <= 1'b1;
                            state_r    <= ST_REQ;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_REQ: begin
                        if (cnt_r == REQ_LAST) begin
                            // Release clock; data stays low as the start bit.
                            cnt_r      <= '0;
                            bit_idx_r  <= 4'd0;
                            ps2_clk_oe <= 1'b0;
                            state_r    <= ST_SHIFT;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_SHIFT: begin
                        cnt_r <= sat_inc(cnt_r);
                        if (clk_fall_s) begin
                            ps2_dat_oe <= ~frame_r[bit_idx_r];
                            if (bit_idx_r == 4'd9) begin
                                bit_idx_r <= 4'd0;
                                state_r   <= ST_ACK;
                            end else begin
                                bit_idx_r <= bit_idx_r + 4'd1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r;
                        end
                    end
                    ST_ACK: begin
                        cnt_r <= sat_inc(cnt_r);
                        if (clk_fall_s) begin
                            // Data high here is handled as a failed attempt.
                            state_r <= ST_WAIT_IDLE;
                        end else begin
                            state_r <= ST_ACK;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_sync2_r && dat_sync2_r) begin
                            tx_done    <= 1'b1;
                            rx_inhibit <= 1'b0;
                            cnt_r      <= '0;
                            state_r    <= ST_IDLE;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_FAIL: begin
                        tx_error   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_IDLE;
                    end
                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        rx_inhibit <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
